// File: rtl/score_keeper_if.sv
// Signal bundle between the video/ball stages and the score keeper.
// master drives the raw game inputs; slave is the score keeper itself.
interface score_keeper_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        vblank;
  logic [10:0] ball_h;
  logic        ball_dir;
  logic        coll_paddle;
  logic        serve_btn;
  logic        ball_reset;
  logic [3:0]  score_left;
  logic [3:0]  score_right;
  logic        game_over;
  logic        winner;
  logic        pixel_valid;

  modport master (
    output hcount, vcount, vblank, ball_h, ball_dir, coll_paddle, serve_btn,
    input  ball_reset, score_left, score_right, game_over, winner, pixel_valid
  );

  modport slave (
    input  hcount, vcount, vblank, ball_h, ball_dir, coll_paddle, serve_btn,
    output ball_reset, score_left, score_right, game_over, winner, pixel_valid
  );
endinterface

// File: rtl/score_keeper.sv
// Game-flow controller: miss detection, serve/point/game-over sequencing and
// a registered score-block overlay drawn at the top of the screen.
module score_keeper #(
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned LEFT_MISS   = 16,
  parameter int unsigned RIGHT_MISS  = 624,
  parameter int unsigned HOLD_FRAMES = 60,
  parameter int unsigned BAR_Y       = 8,
  parameter int unsigned BAR_H       = 8,
  parameter int unsigned BAR_W       = 8,
  parameter int unsigned BAR_PITCH   = 12,
  parameter int unsigned LEFT_X0     = 200,
  parameter int unsigned RIGHT_X0    = 440
) (
  input logic           clk,
  input logic           rst,
  score_keeper_if.slave sk_io
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StPlay  = 2'd1;
  localparam logic [1:0] StPoint = 2'd2;
  localparam logic [1:0] StOver  = 2'd3;

  localparam logic [3:0] WinScore  = 4'(WIN_SCORE);
  localparam logic [5:0] HoldInit  = 6'(HOLD_FRAMES - 1);
  localparam logic [7:0] BarW      = 8'(BAR_W);
  localparam logic [7:0] PitchLast = 8'(BAR_PITCH - 1);

  logic       serve_meta_q, serve_sync_q, serve_prev_q, serve_armed_q;
  logic [1:0] fill_q;
  logic       serve_pulse;
  logic       vblank_q;
  logic       frame_tick;
  logic       left_miss, right_miss;

  logic [1:0] state_q, state_d;
  logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic       winner_q, winner_d;
  logic [5:0] hold_q, hold_d;
  logic       ball_reset_q, game_over_q, pixel_valid_q;
  logic       bar_rows;
  logic [1:0] side_hit;

  // The armed flag blocks a serve edge until the synchronizer has been seen
  // low after reset, so a button held through reset cannot start a rally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      serve_meta_q  <= 1'b0;
      serve_sync_q  <= 1'b0;
      serve_prev_q  <= 1'b0;
      serve_armed_q <= 1'b0;
      fill_q        <= 2'b00;
      vblank_q      <= 1'b0;
    end else begin
      serve_meta_q  <= sk_io.serve_btn;
      serve_sync_q  <= serve_meta_q;
      serve_prev_q  <= serve_sync_q;
      fill_q        <= {fill_q[0], 1'b1};
      serve_armed_q <= serve_armed_q | (fill_q[1] & ~serve_sync_q);
      vblank_q      <= sk_io.vblank;
    end
  end

  assign serve_pulse = serve_armed_q & serve_sync_q & ~serve_prev_q;
  assign frame_tick  = sk_io.vblank & ~vblank_q;
  assign left_miss   = ~sk_io.ball_dir & (sk_io.ball_h <= 11'(LEFT_MISS)) & ~sk_io.coll_paddle;
  assign right_miss  = sk_io.ball_dir & (sk_io.ball_h >= 11'(RIGHT_MISS)) & ~sk_io.coll_paddle;

  // Next-state logic for the game sequence and scores.
  always_comb begin
    state_d   = state_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    winner_d  = winner_q;
    hold_d    = hold_q;
    case (state_q)
      StIdle: begin
        if (serve_pulse) state_d = StPlay;
      end
      StPlay: begin
        if (frame_tick && left_miss) begin
          score_r_d = score_r_q + 4'd1;
          if (score_r_d == WinScore) begin
            state_d  = StOver;
            winner_d = 1'b1;
          end else begin
            state_d = StPoint;
            hold_d  = HoldInit;
          end
        end else if (frame_tick && right_miss) begin
          score_l_d = score_l_q + 4'd1;
          if (score_l_d == WinScore) begin
            state_d  = StOver;
            winner_d = 1'b0;
          end else begin
            state_d = StPoint;
            hold_d  = HoldInit;
          end
        end
      end
      StPoint: begin
        if (frame_tick) begin
          if (hold_q == 6'd0) state_d = StPlay;
          else                hold_d  = hold_q - 6'd1;
        end
      end
      default: begin
        if (serve_pulse) begin
          state_d   = StIdle;
          score_l_d = 4'd0;
          score_r_d = 4'd0;
          winner_d  = 1'b0;
        end
      end
    endcase
  end

  // Game state and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      score_l_q     <= 4'd0;
      score_r_q     <= 4'd0;
      winner_q      <= 1'b0;
      hold_q        <= 6'd0;
      ball_reset_q  <= 1'b1;
      game_over_q   <= 1'b0;
      pixel_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      winner_q      <= winner_d;
      hold_q        <= hold_d;
      ball_reset_q  <= (state_d != StPlay);
      game_over_q   <= (state_d == StOver);
      pixel_valid_q <= bar_rows & (|side_hit);
    end
  end

  assign bar_rows = (sk_io.vcount >= 11'(BAR_Y)) && (sk_io.vcount < 11'(BAR_Y + BAR_H));

  // Per-side block/offset counters: restart when hcount hits the side's X0,
  // then walk one pixel per cycle until the last scored block has passed.
  for (genvar s = 0; s < 2; s++) begin : g_side
    localparam logic [10:0] X0 = (s == 0) ? 11'(LEFT_X0) : 11'(RIGHT_X0);

    logic [3:0] score;
    logic       start;
    logic       act_q, act_d, cur_act;
    logic [3:0] blk_q, blk_d, cur_blk;
    logic [7:0] off_q, off_d, cur_off;

    assign score = (s == 0) ? score_l_q : score_r_q;
    assign start = (sk_io.hcount == X0);

    // Current-pixel position inside the run and the step to the next pixel.
    always_comb begin
      cur_act = start | act_q;
      cur_blk = start ? 4'd0 : blk_q;
      cur_off = start ? 8'd0 : off_q;
      if (cur_off == PitchLast) begin
        off_d = 8'd0;
        blk_d = cur_blk + 4'd1;
      end else begin
        off_d = cur_off + 8'd1;
        blk_d = cur_blk;
      end
      act_d       = cur_act & (blk_d < score);
      side_hit[s] = cur_act & (cur_blk < score) & (cur_off < BarW);
    end

    // Overlay counter state for this side.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        act_q <= 1'b0;
        blk_q <= 4'd0;
        off_q <= 8'd0;
      end else begin
        act_q <= act_d;
        blk_q <= blk_d;
        off_q <= off_d;
      end
    end
  end

  assign sk_io.ball_reset  = ball_reset_q;
  assign sk_io.score_left  = score_l_q;
  assign sk_io.score_right = score_r_q;
  assign sk_io.game_over   = game_over_q;
  assign sk_io.winner      = winner_q;
  assign sk_io.pixel_valid = pixel_valid_q;

endmodule
